// File: rtl/galaksija_tape_player.sv
// Galaksija cassette playback engine: streams tape buffer bytes as the
// pulse-coded bit level the ROM samples at $2000.
module galaksija_tape_player #(
  parameter int ADDR_W    = 14,
  parameter int CNT_W     = 16,
  parameter int STEP_CYC  = 1152,
  parameter int GAP_CYC   = 13002,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] end_addr,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [7:0]        buf_data,
  output logic              tape_out,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD,
    PLAY
  } state_t;

  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

  state_t            state;
  logic [ADDR_W-1:0] end_q;
  logic [7:0]        data_q;
  logic [2:0]        bit_idx;
  logic [2:0]        phase;
  logic [CNT_W-1:0]  dly;

  logic       last_bit;
  logic       last_phase;
  logic       phase_end;
  logic       cur_bit;
  logic       run;
  logic [2:0] phase_nxt;

  assign last_bit   = bit_idx == 3'd7;
  assign last_phase = phase == 3'd7;
  // The final phase of a byte is the long inter-byte gap.
  assign phase_end  = dly == ((last_bit && last_phase) ? GAP_LAST : STEP_LAST);
  assign cur_bit    = LSB_FIRST ? data_q[bit_idx] : data_q[3'd7 - bit_idx];
  assign run        = ce && !pause;
  assign phase_nxt  = phase + 3'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      buf_addr <= '0;
      end_q    <= '0;
      data_q   <= '0;
      bit_idx  <= '0;
      phase    <= '0;
      dly      <= '0;
      tape_out <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state    <= IDLE;
        busy     <= 1'b0;
        tape_out <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (start) begin
              if (start_addr > end_addr) begin
                done <= 1'b1;
              end else begin
                end_q    <= end_addr;
                buf_addr <= start_addr;
                busy     <= 1'b1;
                state    <= FETCH;
              end
            end
          end
          FETCH: state <= LOAD;
          LOAD: begin
            data_q   <= buf_data;
            bit_idx  <= '0;
            phase    <= '0;
            dly      <= '0;
            tape_out <= 1'b0;
            state    <= PLAY;
          end
          PLAY: begin
            if (run) begin
              if (!phase_end) begin
                dly <= dly + 1'b1;
              end else begin
                dly <= '0;
                if (!last_phase) begin
                  phase    <= phase_nxt;
                  tape_out <= (phase_nxt == 3'd4) ? ~cur_bit : 1'b1;
                end else if (!last_bit) begin
                  phase    <= '0;
                  bit_idx  <= bit_idx + 3'd1;
                  tape_out <= 1'b0;
                end else begin
                  phase    <= '0;
                  bit_idx  <= '0;
                  tape_out <= 1'b1;
                  // Compare before increment so the top address never wraps.
                  if (buf_addr == end_q) begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                  end else begin
                    buf_addr <= buf_addr + 1'b1;
                    state    <= FETCH;
                  end
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
